// File: rtl/sha256_block_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sha256_block_sequencer                                       |
// | Description : Walks one whole message through the SHA-256 fetch/padding    |
// |               path, one 512-bit block at a time. For each block it issues  |
// |               16 word reads and drives the padder's start/enable. It then  |
// |               raises a block-valid handshake toward the compression core   |
// |               and waits for the acknowledge. The total block count is      |
// |               derived from the byte length, including the padding-overflow |
// |               block.                                                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// Ports:
//   clk        in   1   rising-edge clock
//   resetn     in   1   asynchronous active-low reset
//   go         in   1   start-of-message pulse, sampled only while idle
//   msg_size   in  64   message length in bytes, stable from go until done
//   busy       out  1   high in every state except idle
//   done       out  1   one-cycle pulse after the last block is acknowledged
//   err        out  1   sticky padding-consistency error, cleared by next go
//   rd_en      out  1   message-store read strobe
//   rd_addr    out 59   word address {cur_block, offset}
//   cur_block  out 55   current block index to the padder
//   offset     out  4   word index within the block to the padder
//   pad_start  out  1   padder start pulse (first word of each block)
//   pad_en     out  1   padder enable
//   pad_of     in   1   padder overflow indication
//   w_valid    out  1   padder output word valid this cycle
//   blk_valid  out  1   16 words delivered, waiting on the core
//   blk_ack    in   1   compression core accepts the block
module sha256_block_sequencer #(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        go,
  input  logic [63:0] msg_size,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        rd_en,
  output logic [58:0] rd_addr,
  output logic [54:0] cur_block,
  output logic [3:0]  offset,
  output logic        pad_start,
  output logic        pad_en,
  input  logic        pad_of,
  output logic        w_valid,
  output logic        blk_valid,
  input  logic        blk_ack
);

  // One stage for the store read, one for the padder output register.
  localparam int WV_DEPTH = RD_LAT + 1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_DRAIN    = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  state_e              state_q,     state_d;
  logic [54:0]         cur_block_q, cur_block_d;
  logic [3:0]          offset_q,    offset_d;
  logic                drain_cnt_q, drain_cnt_d;
  logic                err_q,       err_d;
  logic [WV_DEPTH-1:0] wv_pipe_q,   wv_pipe_d;

  logic [54:0] last_idx;
  logic        tail_overflows;
  logic        is_last_block;
  logic        pad_of_expected;
  logic        unused_msg_hi;

  // A tail of more than 55 bytes leaves no room for the 0x80 marker plus the
  // 64-bit length, so the padding spills into one extra block.
  assign tail_overflows  = msg_size[5:0] > 6'd55;
  assign last_idx        = msg_size[60:6] + {54'd0, tail_overflows};
  assign is_last_block   = (cur_block_q == last_idx);
  // Only the block before the spill block should see the padder overflow.
  // When tail_overflows is set, last_idx is at least 1, so no underflow.
  assign pad_of_expected = tail_overflows && (cur_block_q == (last_idx - 55'd1));

  // Block indices are 55 bits wide; the top length bits cannot be addressed.
  assign unused_msg_hi   = ^msg_size[63:61];

  // --------------------------------------------------------------------------
  // Next-state and sequencing logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cur_block_d = cur_block_q;
    offset_d    = offset_q;
    drain_cnt_d = drain_cnt_q;
    err_d       = err_q;

    case (state_q)
      ST_IDLE: begin
        if (go) begin
          err_d       = 1'b0;
          cur_block_d = 55'd0;
          offset_d    = 4'd0;
          state_d     = ST_FETCH;
        end
      end

      ST_FETCH: begin
        // Wraps to 0 after word 15, ready for the next block.
        offset_d = offset_q + 4'd1;
        if (offset_q == 4'd15) begin
          if (pad_of != pad_of_expected) begin
            err_d = 1'b1;
          end
          drain_cnt_d = 1'b0;
          state_d     = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        // Two cycles: flush the read stage, then the padder register stage.
        if (drain_cnt_q) begin
          drain_cnt_d = 1'b0;
          state_d     = ST_WAIT_ACK;
        end else begin
          drain_cnt_d = 1'b1;
        end
      end

      ST_WAIT_ACK: begin
        if (blk_ack) begin
          if (is_last_block) begin
            state_d = ST_DONE;
          end else begin
            cur_block_d = cur_block_q + 55'd1;
            offset_d    = 4'd0;
            state_d     = ST_FETCH;
          end
        end
      end

      ST_DONE: begin
        // Leave the address at zero so that idle presents all-zero outputs.
        cur_block_d = 55'd0;
        offset_d    = 4'd0;
        state_d     = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Word-valid follows the fetch flag by the read latency plus the padder stage.
  assign wv_pipe_d = {wv_pipe_q[WV_DEPTH-2:0], (state_q == ST_FETCH)};

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      cur_block_q <= 55'd0;
      offset_q    <= 4'd0;
      drain_cnt_q <= 1'b0;
      err_q       <= 1'b0;
      wv_pipe_q   <= '0;
    end else begin
      state_q     <= state_d;
      cur_block_q <= cur_block_d;
      offset_q    <= offset_d;
      drain_cnt_q <= drain_cnt_d;
      err_q       <= err_d;
      wv_pipe_q   <= wv_pipe_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: decoded from registered state only, no input-to-output path
  // --------------------------------------------------------------------------
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    rd_en     = 1'b0;
    pad_start = 1'b0;
    pad_en    = 1'b0;
    blk_valid = 1'b0;

    case (state_q)
      ST_FETCH: begin
        busy      = 1'b1;
        rd_en     = 1'b1;
        pad_en    = 1'b1;
        pad_start = (offset_q == 4'd0);
      end
      ST_DRAIN: begin
        busy   = 1'b1;
        pad_en = 1'b1;
      end
      ST_WAIT_ACK: begin
        busy      = 1'b1;
        blk_valid = 1'b1;
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign err       = err_q;
  assign cur_block = cur_block_q;
  assign offset    = offset_q;
  assign rd_addr   = {cur_block_q, offset_q};
  assign w_valid   = wv_pipe_q[WV_DEPTH-1];

endmodule
`default_nettype wire

// File: tb/tb_sha256_block_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sha256_block_sequencer                                    |
// | Description : Self-checking bench. A schedule model derives every block's  |
// |               fetch/drain/wait window from the message length and the      |
// |               chosen acknowledge delays, and each cycle's outputs are      |
// |               compared against window membership.                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_sha256_block_sequencer;

  localparam int MAXB = 16;

  logic        clk = 1'b0;
  logic        resetn;
  logic        go;
  logic [63:0] msg_size;
  logic        pad_of;
  logic        blk_ack;
  logic        busy, done, err, rd_en, pad_start, pad_en, w_valid, blk_valid;
  logic [58:0] rd_addr;
  logic [54:0] cur_block;
  logic [3:0]  offset;

  int   n_vec = 0;
  int   n_miscompare = 0;
  int   cyc = 0;
  int   dly [MAXB];
  logic err_prev;

  sha256_block_sequencer #(.RD_LAT(1)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .go        (go),
    .msg_size  (msg_size),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .cur_block (cur_block),
    .offset    (offset),
    .pad_start (pad_start),
    .pad_en    (pad_en),
    .pad_of    (pad_of),
    .w_valid   (w_valid),
    .blk_valid (blk_valid),
    .blk_ack   (blk_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog @%0d: got no end of test, expected summary", cyc);
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscompare++;
      $display("FAIL %s @%0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".busy"},      busy,      0);
    check_eq({tag, ".done"},      done,      0);
    check_eq({tag, ".err"},       err,       0);
    check_eq({tag, ".rd_en"},     rd_en,     0);
    check_eq({tag, ".pad_en"},    pad_en,    0);
    check_eq({tag, ".pad_start"}, pad_start, 0);
    check_eq({tag, ".w_valid"},   w_valid,   0);
    check_eq({tag, ".blk_valid"}, blk_valid, 0);
    check_eq({tag, ".cur_block"}, cur_block, 0);
    check_eq({tag, ".offset"},    offset,    0);
    check_eq({tag, ".rd_addr"},   rd_addr,   0);
  endtask

  task automatic set_dly(input int v);
    for (int i = 0; i < MAXB; i++) dly[i] = v;
  endtask

  // Runs one message. force_blk >= 0 drives the wrong pad_of for that block;
  // abort_at > 0 pulls reset in that message cycle.
  task automatic run_msg(input logic [63:0] size, input int force_blk, input int abort_at);
    longint last;
    int     s [MAXB];
    int     done_c;
    int     err_at;
    logic   good;
    logic   e_fetch, e_drain, e_wait, e_wv, e_err;
    int     e_blk, e_off;

    last = longint'(size >> 6) + ((size[5:0] > 6'd55) ? 1 : 0);
    s[0] = 1;
    for (int b = 1; b <= last; b++) s[b] = s[b-1] + 19 + dly[b-1];
    done_c = s[last] + 19 + dly[last];
    err_at = 0;

    // Cycle 0: idle, go sampled.
    msg_size = size;
    go       = 1'b1;
    blk_ack  = 1'($urandom);
    pad_of   = 1'($urandom);
    check_eq("idle.busy",    busy,      0);
    check_eq("idle.done",    done,      0);
    check_eq("idle.rd_en",   rd_en,     0);
    check_eq("idle.pad_en",  pad_en,    0);
    check_eq("idle.blk_vld", blk_valid, 0);
    check_eq("idle.w_valid", w_valid,   0);
    check_eq("idle.err",     err,       err_prev);
    @(posedge clk); #1;

    for (int c = 1; c <= done_c + 2; c++) begin
      e_fetch = 0; e_drain = 0; e_wait = 0; e_wv = 0; e_blk = 0; e_off = 0;
      for (int b = 0; b <= last; b++) begin
        if (c >= s[b] && c <= s[b] + 15) begin e_fetch = 1; e_blk = b; e_off = c - s[b]; end
        if (c >= s[b] + 16 && c <= s[b] + 17) begin e_drain = 1; e_blk = b; end
        if (c >= s[b] + 18 && c <= s[b] + 18 + dly[b]) begin e_wait = 1; e_blk = b; end
        if (c >= s[b] + 2 && c <= s[b] + 17) e_wv = 1;
      end

      // Stimulus for this cycle.
      go = (c <= done_c) ? 1'($urandom) : 1'b0;
      if (e_wait) blk_ack = (c == s[e_blk] + 18 + dly[e_blk]);
      else        blk_ack = 1'($urandom);
      if (e_fetch && e_off == 15) begin
        good   = (longint'(e_blk) == last - 1) && (size[5:0] > 6'd55);
        pad_of = good ^ (e_blk == force_blk);
        if (e_blk == force_blk && err_at == 0) err_at = c + 1;
      end else begin
        pad_of = 1'($urandom);
      end

      if (abort_at > 0 && c == abort_at) begin
        #2 resetn = 1'b0;
        #1 check_all_zero("abort.async");
        @(posedge clk); #1;
        check_all_zero("abort.edge");
        resetn = 1'b1;
        go     = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(posedge clk); #1;
          check_all_zero("abort.after");
        end
        err_prev = 1'b0;
        return;
      end

      e_err = (err_at != 0) && (c >= err_at);
      check_eq("busy",      busy,      (c <= done_c));
      check_eq("done",      done,      (c == done_c));
      check_eq("rd_en",     rd_en,     e_fetch);
      check_eq("pad_en",    pad_en,    e_fetch | e_drain);
      check_eq("pad_start", pad_start, e_fetch && e_off == 0);
      check_eq("w_valid",   w_valid,   e_wv);
      check_eq("blk_valid", blk_valid, e_wait);
      check_eq("err",       err,       e_err);
      if (e_fetch) begin
        check_eq("offset",    offset,    64'(e_off));
        check_eq("cur_block", cur_block, 64'(e_blk));
        check_eq("rd_addr",   rd_addr,   (64'(e_blk) << 4) | 64'(e_off));
      end else if (e_drain || e_wait) begin
        check_eq("cur_block", cur_block, 64'(e_blk));
      end
      @(posedge clk); #1;
      err_prev = e_err;
    end
  endtask

  initial begin
    int sz;
    int fb;
    resetn   = 1'b0;
    go       = 1'b0;
    msg_size = '0;
    pad_of   = 1'b0;
    blk_ack  = 1'b0;
    err_prev = 1'b0;
    set_dly(0);
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    resetn = 1'b1;
    @(posedge clk); #1;
    check_all_zero("reset.rel");

    // Directed cases.
    run_msg(64'd3,   -1, 0);
    run_msg(64'd0,   -1, 0);
    run_msg(64'd55,  -1, 0);
    run_msg(64'd56,  -1, 0);
    run_msg(64'd128, -1, 0);
    dly[0] = 10;
    run_msg(64'd100, -1, 0);
    set_dly(0);
    run_msg(64'd10,   0, 0);
    run_msg(64'd10,  -1, 0);
    run_msg(64'd100, -1, 27);
    run_msg(64'd3,   -1, 0);

    // Randomized messages.
    for (int m = 0; m < 24; m++) begin
      sz = $urandom_range(0, 700);
      for (int i = 0; i < MAXB; i++) dly[i] = $urandom_range(0, 3);
      fb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, sz / 64) : -1;
      run_msg(64'(sz), fb, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sha256_block_sequencer.md
# sha256_block_sequencer

Sequences the message-word fetch and padding pipeline of the SHA256 accelerator for one whole message. It walks the message store one 512-bit block at a time, driving the word address (`cur_block`, `offset`) and the `start`/`en` controls to the padder. Per block it emits exactly 16 valid padded words toward the scheduler, then holds a block handshake with the compression core. It decides the total block count from the byte length, including the padding-overflow block.

## Interface
Parameters:
- `RD_LAT`, 1: message-store read latency in cycles. The only supported value is 1; the word-valid latency below assumes it.

Ports:
- `clk`  in  1  rising-edge clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `go`  in  1  start-of-message pulse; sampled only in IDLE.
- `msg_size`  in  64  message length in bytes; must be held stable from `go` until `done`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the last block is acknowledged.
- `err`  out  1  sticky padding-consistency error; cleared by the next accepted `go`.
- `rd_en`  out  1  message-store read strobe.
- `rd_addr`  out  59  word address, `{cur_block, offset}`.
- `cur_block`  out  55  current block index, to the padder.
- `offset`  out  4  word index within the block, to the padder.
- `pad_start`  out  1  start pulse to the padder.
- `pad_en`  out  1  enable to the padder.
- `pad_of`  in  1  padder overflow indication.
- `w_valid`  out  1  marks a valid padder output word this cycle.
- `blk_valid`  out  1  block of 16 words complete; waiting on the core.
- `blk_ack`  in  1  compression core accepts the block.

## Operation
- **Block count.** `last_idx = msg_size[63:6] + (msg_size[5:0] > 55)`, computed in 55 bits. Blocks run from 0 to `last_idx` inclusive.
  - `msg_size = 0` is legal and gives one block.
  - A length that is a multiple of 64 gets a final block containing only padding.
- **IDLE.**
  - All control outputs are 0.
  - On `go`: clear `err`, set `cur_block = 0` and `offset = 0`, go to FETCH.
- **FETCH (16 cycles).**
  - `rd_en = 1`, `pad_en = 1`.
  - `pad_start = 1` only in the cycle where `offset = 0`.
  - `offset` increments each cycle. At `offset = 15`, go to DRAIN.
- **DRAIN (2 cycles).**
  - `pad_en = 1`, `rd_en = 0`; flushes the read and padder-register stages.
  - Then go to WAIT_ACK.
- **WAIT_ACK.**
  - `blk_valid = 1` and `pad_en = 0`, which freezes the padder.
  - When `blk_ack` is high:
    - If `cur_block == last_idx`: go to DONE.
    - Otherwise: `cur_block += 1`, `offset = 0`, go to FETCH.
- **DONE.** One cycle with `done = 1`, then IDLE.
- **`w_valid`.** A 2-deep shift of the FETCH-active flag. Exactly 16 `w_valid` cycles occur per block.
- **Consistency check.** In the FETCH cycle where `offset = 15`, set `err` (sticky) if `pad_of != (cur_block == last_idx-1 && msg_size[5:0] > 55)`.
  - A set `err` does not alter sequencing.
- **Ignored inputs.**
  - `go` while `busy` is ignored.
  - `blk_ack` outside WAIT_ACK is ignored.
- **Reset.**
  - `resetn` low at any time, including mid-block, immediately forces IDLE.
  - All outputs go to 0: `cur_block = 0`, `offset = 0`, `err = 0`, and the `w_valid` pipe is cleared.
  - No `done` is issued for the aborted message.

## Timing
- Cycle 0: `go` is sampled in IDLE.
- Cycles 1–16: FETCH, with `offset` 0..15 and `pad_start` high in cycle 1.
- Word data: `rd_addr` is issued at cycle t, read data arrives at t+1, and the padder output is valid at t+2. `w_valid` is therefore high in cycles 3–18.
- Cycles 17–18: DRAIN.
- Cycle 19 onward: `blk_valid` is high. If `blk_ack` is high in cycle 19, the next block's FETCH starts at cycle 20, or `done` is pulsed at cycle 20.
- Minimum block period is 19 cycles; each cycle of `blk_ack` delay adds one cycle.
- `done` and `blk_valid` are registered outputs with no combinational input-to-output path.
- `busy` falls the cycle after `done`.

## Test plan
- **Short message.** `msg_size = 3`, `go`, `blk_ack` held high → one block, 16 `w_valid` pulses in cycles 3–18, `rd_addr` 0..15, `done` at cycle 20, `err = 0`.
- **Overflow boundary.**
  - `msg_size = 55` → one block.
  - `msg_size = 56` → two blocks; padder `pad_of` high at block 0, offset 15; `err = 0`; 32 `w_valid` pulses total.
- **Multiple of 64.** `msg_size = 128` → three blocks, `cur_block` 0,1,2, second block's `rd_addr` 16..31, `done` once.
- **Backpressure.** `blk_ack` delayed 10 cycles on block 0 of `msg_size = 100` → `blk_valid` high for 11 cycles, `rd_en` and `pad_en` low throughout, block 1 FETCH begins the cycle after `blk_ack`.
- **Reset mid-operation.** `resetn` pulled low at `offset = 7` of block 1 → next edge: IDLE, all outputs 0, no `done`. A new `go` with `msg_size = 3` then completes normally.
- **Forced mismatch.** Drive `pad_of = 1` with `msg_size = 10` → `err` set after offset 15 and held through `done`; cleared on the next `go`.
